// File: rtl/varredor_display.sv
// rtl/varredor_display.sv - four-digit 7-segment scanner with slot FSM, anti-ghost blanking and per-frame snapshots
//
// Purpose:
//   Scans a 4-digit common-anode 7-segment display. Each frame is four slots
//   of SCAN_DIV cycles. Every slot opens with BLANK_CYCLES cycles of all-dark
//   output, which keeps the previous digit's pattern from bleeding into the
//   next digit. Slot 1 shows the action code, slots 2 and 3 stay dark, and
//   slot 4 shows the speed selection plus one, with the decimal point lit.
//   The action code and speed are captured once per frame, at frame start,
//   so a frame never shows a mix of old and new values.
//
//   Optional macro CHANGE_FLASH_EN: when defined, a change of the action code
//   between frames makes digit 1 blink for FLASH_FRAMES frames (dark on frames
//   where the flash counter is odd). When undefined, no flash logic exists.
//
// Ports:
//   clock_entrada       in   system clock
//   reset               in   synchronous, active-high
//   power               in   1 = scanning, 0 = display dark and scan parked
//   acoes[2:0]          in   action code 0..7
//   chave1, chave2      in   speed select bits 0 and 1
//   a..g                out  segment lines, active-low
//   p                   out  decimal point, active-low
//   d1..d4              out  digit enables, active-low
module varredor_display #(
  parameter int SCAN_DIV     = 2048,
  parameter int BLANK_CYCLES = 64,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clock_entrada,
  input  logic       reset,
  input  logic       power,
  input  logic [2:0] acoes,
  input  logic       chave1,
  input  logic       chave2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       p,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  // Reject parameter sets where a slot could not hold both phases.
  if (SCAN_DIV < 4 || SCAN_DIV > 65535 || BLANK_CYCLES < 1 ||
      BLANK_CYCLES > SCAN_DIV - 2 || FLASH_FRAMES < 1) begin : g_bad_params
    $error("varredor_display: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S1_BLANK = 3'd0,
    S1_SHOW  = 3'd1,
    S2_BLANK = 3'd2,
    S2_SHOW  = 3'd3,
    S3_BLANK = 3'd4,
    S3_SHOW  = 3'd5,
    S4_BLANK = 3'd6,
    S4_SHOW  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    act_q;
  logic [1:0]    spd_q;

  logic [6:0]    seg_q, seg_d;   // g f e d c b a
  logic          p_q, p_d;
  logic [3:0]    dig_q, dig_d;   // d4 d3 d2 d1

  logic          frame_start;
  logic          flash_dark;

  // Glyph table, bit order g f e d c b a, active-low.
  function automatic logic [6:0] glyph(input logic [2:0] v);
    case (v)
      3'd0:    return 7'b1000000;
      3'd1:    return 7'b1111001;
      3'd2:    return 7'b0100100;
      3'd3:    return 7'b0110000;
      3'd4:    return 7'b0011001;
      3'd5:    return 7'b0010010;
      3'd6:    return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  // While power is low the FSM is parked at slot 1 BLANK with counter 0, so
  // the first powered cycle is automatically a frame start.
  assign frame_start = power && (state_q == S1_BLANK) && (cnt_q == '0);

  // Next-state: BLANK ends after BLANK_CYCLES cycles, SHOW ends at the slot
  // boundary, where the counter also wraps back to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S1_BLANK: if (cnt_q == BLANK_LAST) state_d = S1_SHOW;
      S1_SHOW:  if (cnt_q == CNT_LAST)   state_d = S2_BLANK;
      S2_BLANK: if (cnt_q == BLANK_LAST) state_d = S2_SHOW;
      S2_SHOW:  if (cnt_q == CNT_LAST)   state_d = S3_BLANK;
      S3_BLANK: if (cnt_q == BLANK_LAST) state_d = S3_SHOW;
      S3_SHOW:  if (cnt_q == CNT_LAST)   state_d = S4_BLANK;
      S4_BLANK: if (cnt_q == BLANK_LAST) state_d = S4_SHOW;
      S4_SHOW:  if (cnt_q == CNT_LAST)   state_d = S1_BLANK;
      default:                           state_d = S1_BLANK;
    endcase
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
    if (!power) begin
      state_d = S1_BLANK;
      cnt_d   = '0;
    end
  end

  // Pin decode from the current state; registered below for clean pins.
  always_comb begin
    seg_d = 7'h7F;
    p_d   = 1'b1;
    dig_d = 4'hF;
    case (state_q)
      S1_SHOW: begin
        seg_d = glyph(act_q);
        dig_d = flash_dark ? 4'b1111 : 4'b1110;
      end
      S4_SHOW: begin
        seg_d = glyph({1'b0, spd_q} + 3'd1);
        p_d   = 1'b0;
        dig_d = 4'b0111;
      end
      default: begin
        seg_d = 7'h7F;
      end
    endcase
    if (!power) begin
      seg_d = 7'h7F;
      p_d   = 1'b1;
      dig_d = 4'hF;
    end
  end

  always_ff @(posedge clock_entrada) begin
    if (reset) begin
      state_q <= S1_BLANK;
      cnt_q   <= '0;
      act_q   <= '0;
      spd_q   <= '0;
      seg_q   <= 7'h7F;
      p_q     <= 1'b1;
      dig_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      p_q     <= p_d;
      dig_q   <= dig_d;
      if (frame_start) begin
        act_q <= acoes;
        spd_q <= {chave2, chave1};
      end
    end
  end

`ifdef CHANGE_FLASH_EN
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic [FW-1:0] flash_q;

  // Compared against the snapshot before it is overwritten at frame start.
  always_ff @(posedge clock_entrada) begin
    if (reset || !power) begin
      flash_q <= '0;
    end else if (frame_start) begin
      if (acoes != act_q) begin
        flash_q <= FW'(FLASH_FRAMES);
      end else if (flash_q != '0) begin
        flash_q <= flash_q - 1'b1;
      end
    end
  end

  // An odd count is necessarily nonzero.
  assign flash_dark = flash_q[0];
`else
  assign flash_dark = 1'b0;
`endif

  assign {g, f, e, d, c, b, a} = seg_q;
  assign p                     = p_q;
  assign {d4, d3, d2, d1}      = dig_q;

endmodule

// File: tb/tb_varredor_display.sv
// tb/tb_varredor_display.sv - self-checking bench for varredor_display
module tb_varredor_display;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FF    = 4;
  localparam int FRAME = 4 * SD;

  localparam logic [11:0] OFF = 12'hFFF;
  localparam logic [6:0]  GL1 = 7'b1111001;
  localparam logic [6:0]  GL2 = 7'b0100100;
  localparam logic [6:0]  GL3 = 7'b0110000;
  localparam logic [6:0]  GL4 = 7'b0011001;
  localparam logic [6:0]  GL5 = 7'b0010010;
  localparam logic [6:0]  GL6 = 7'b0000010;

  logic       clk = 1'b0;
  logic       reset;
  logic       power;
  logic [2:0] acoes;
  logic       chave1;
  logic       chave2;
  logic       a, b, c, d, e, f, g, p, d1, d2, d3, d4;
  logic [11:0] pins;

  always #5 clk = ~clk;

  varredor_display #(
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC),
    .FLASH_FRAMES(FF)
  ) dut (
    .clock_entrada(clk),
    .reset(reset),
    .power(power),
    .acoes(acoes),
    .chave1(chave1),
    .chave2(chave2),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .p(p),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4)
  );

  // {digit enables d4..d1, decimal point, segments g..a}
  assign pins = {d4, d3, d2, d1, p, g, f, e, d, c, b, a};

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  // Reference model: position within the frame plus the captured values.
  int         m_pos   = 0;
  logic [2:0] m_act   = '0;
  logic [1:0] m_spd   = '0;
  int         m_flash = 0;

  function automatic logic [11:0] s1(input logic [6:0] gl);
    return {4'b1110, 1'b1, gl};
  endfunction

  function automatic logic [11:0] s4(input logic [6:0] gl);
    return {4'b0111, 1'b0, gl};
  endfunction

  function automatic logic [11:0] render(input int pos);
    int slot = pos / SD;
    int off  = pos % SD;
    logic [11:0] r = OFF;
    if (off >= BC) begin
      if (slot == 0) begin
        r = s1(glyph_tab[m_act]);
`ifdef CHANGE_FLASH_EN
        if (m_flash % 2 == 1) r[11:8] = 4'b1111;
`endif
      end else if (slot == 3) begin
        r = s4(glyph_tab[int'(m_spd) + 1]);
      end
    end
    return r;
  endfunction

  // Expected pins after the coming edge, then advance the model by one cycle.
  task automatic model_step(output logic [11:0] exp);
    if (reset) begin
      exp = OFF; m_pos = 0; m_act = '0; m_spd = '0; m_flash = 0;
    end else if (!power) begin
      exp = OFF; m_pos = 0; m_flash = 0;
    end else begin
      exp = render(m_pos);
      if (m_pos == 0) begin
        if (acoes != m_act) m_flash = FF;
        else if (m_flash > 0) m_flash = m_flash - 1;
        m_act = acoes;
        m_spd = {chave2, chave1};
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    logic [11:0] exp;
    model_step(exp);
    @(posedge clk);
    #1;
    check("model", pins, exp);
    check("one_digit", {11'b0, ($countones(~pins[11:8]) <= 1)}, 12'd1);
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (m_pos != target && n < 4 * FRAME) begin
      tick();
      n++;
    end
    if (m_pos != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos: got position %0d required %0d", m_pos, target);
    end
  endtask

  task automatic set_spd(input logic [1:0] s);
    {chave2, chave1} = s;
  endtask

  typedef struct {
    logic        pwr;
    logic [2:0]  act;
    logic [1:0]  spd;
    int          first;
    int          last;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [$];
  logic [6:0] spd_gl [0:3];
  logic exp_d1 [0:5];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    spd_gl = '{GL1, GL2, GL3, GL4};
`ifdef CHANGE_FLASH_EN
    exp_d1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_d1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Cycle n = pins after the n-th edge following reset release.
    tbl.push_back('{1'b1, 3'd3, 2'd0,  1,  2, OFF});
    tbl.push_back('{1'b1, 3'd3, 2'd0,  3,  8, s1(GL3)});
    tbl.push_back('{1'b1, 3'd3, 2'd0,  9, 26, OFF});
    tbl.push_back('{1'b1, 3'd3, 2'd0, 27, 32, s4(GL1)});
    tbl.push_back('{1'b1, 3'd5, 2'd0, 33, 34, OFF});
    tbl.push_back('{1'b1, 3'd5, 2'd0, 35, 40, s1(GL5)});
    tbl.push_back('{1'b1, 3'd5, 2'd0, 41, 44, OFF});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 45, 58, OFF});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 59, 64, s4(GL1)});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 65, 66, OFF});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 67, 72, s1(GL6)});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 73, 90, OFF});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 91, 96, s4(GL1)});

    reset = 1'b1; power = 1'b1; acoes = 3'd3; set_spd(2'd0);
    tick();
    tick();
    check("reset_state", pins, OFF);
    reset = 1'b0;

    foreach (tbl[i]) begin
      power = tbl[i].pwr;
      acoes = tbl[i].act;
      set_spd(tbl[i].spd);
      for (int cyc = tbl[i].first; cyc <= tbl[i].last; cyc++) begin
        tick();
        check($sformatf("tbl%0d_cyc%0d", i, cyc), pins, tbl[i].exp);
      end
    end

    // power drop during slot 4 SHOW, then power back up
    wait_pos(28);
    power = 1'b0;
    tick();
    check("pwr_off", pins, OFF);
    tick();
    tick();
    check("pwr_off_hold", pins, OFF);
    power = 1'b1;
    tick();
    check("pwr_up_c1", pins, OFF);
    tick();
    check("pwr_up_c2", pins, OFF);
    tick();
    check("pwr_up_c3", pins, s1(GL6));

    // reset in the middle of slot 1
    wait_pos(5);
    reset = 1'b1;
    tick();
    check("rst_mid", pins, OFF);
    reset = 1'b0;
    tick();
    check("rst_rel_c1", pins, OFF);
    tick();
    check("rst_rel_c2", pins, OFF);
    tick();
    check("rst_rel_c3", pins, s1(GL6));

    // speed sweep, one frame per setting
    wait_pos(0);
    for (int s = 0; s < 4; s++) begin
      set_spd(2'(s));
      tick();
      wait_pos(28);
      check($sformatf("speed_%0d", s), pins, s4(spd_gl[s]));
      wait_pos(0);
    end

    // settle on action 2, then change to 4 at a frame start
    acoes = 3'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
      wait_pos(0);
    end
    acoes = 3'd4;
    for (int fr = 0; fr < 6; fr++) begin
      tick();
      wait_pos(4);
      check($sformatf("flash_frame%0d_d1", fr), {11'b0, pins[8]}, {11'b0, exp_d1[fr]});
      wait_pos(0);
    end

    // randomized stimulus against the model
    for (int k = 0; k < 800; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      power = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 15) == 0) acoes = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) set_spd(2'($urandom_range(0, 3)));
      tick();
    end
    reset = 1'b0;
    power = 1'b1;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
